// File: rtl/me_pkg.sv
// Shared parameters and the candidate record used by the me_sad_search_engine compare stages.
package me_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned BLK       = 16;
  localparam int unsigned SR        = 8;
  localparam int unsigned WIN       = BLK + SR - 1;
  localparam int unsigned SAD_W     = 16;
  localparam int unsigned ROW_SAD_W = 12;
  localparam int unsigned MV_W      = 3;

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [MV_W-1:0]  dx;
    logic [MV_W-1:0]  dy;
  } cand_t;

endpackage

// File: rtl/me_sad_row_pe.sv
// One reference row against one current-block row: eight row-SADs, one per horizontal offset dx.
module me_sad_row_pe
  import me_pkg::*;
(
  input  logic [WIN*PIX_W-1:0]            ref_row,
  input  logic [BLK*PIX_W-1:0]            cur_row,
  output logic [SR-1:0][ROW_SAD_W-1:0]    row_sad
);

  logic [PIX_W-1:0]     a;
  logic [PIX_W-1:0]     b;
  logic [ROW_SAD_W-1:0] sum;

  always_comb begin
    row_sad = '0;
    a       = '0;
    b       = '0;
    sum     = '0;
    for (int unsigned dx = 0; dx < SR; dx++) begin
      sum = '0;
      for (int unsigned k = 0; k < BLK; k++) begin
        a   = ref_row[(WIN-1-(dx+k))*PIX_W +: PIX_W];
        b   = cur_row[(BLK-1-k)*PIX_W +: PIX_W];
        sum = sum + ROW_SAD_W'((a > b) ? (a - b) : (b - a));
      end
      row_sad[dx] = sum;
    end
  end

endmodule

// File: rtl/me_sad_search_engine.sv
// Full-search 16x16 SAD engine over 8x8 offsets; streams 23 window rows, reports min SAD and MV.
// Optional ME_CUR_DBUF_EN: double-buffered current block, banks swap when row 0 is accepted.
module me_sad_search_engine
  import me_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIN*PIX_W-1:0]   ref_row,
  input  logic                   ref_valid,
  input  logic                   cur_we,
  input  logic [3:0]             cur_addr,
  input  logic [BLK*PIX_W-1:0]   cur_row,
  output logic                   busy,
  output logic [SAD_W-1:0]       best_sad,
  output logic [MV_W-1:0]        mv_x,
  output logic [MV_W-1:0]        mv_y,
  output logic                   result_valid
);

  logic [4:0]                   row_cnt;
  logic                         row_last;
  logic [4:0]                   cur_idx;
  logic [BLK*PIX_W-1:0]         cur_sel [SR];
  logic [SR-1:0][ROW_SAD_W-1:0] row_sad [SR];
  logic [SAD_W-1:0]             acc [SR][SR];
  logic                         v0, v1;
  cand_t                        s1_d [SR];
  cand_t                        s1_q [SR];
  cand_t                        s2_d;

  assign row_last = (row_cnt == 5'(WIN-1));
  assign busy     = (row_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst)            row_cnt <= '0;
    else if (ref_valid) row_cnt <= row_last ? '0 : row_cnt + 5'd1;
  end

`ifdef ME_CUR_DBUF_EN
  logic [BLK*PIX_W-1:0] cur_mem [2][BLK];
  logic act_bank, pend, swap, rd_bank, wr_bank;

  // Row 0 of a swapping window already reads the new bank; writes land in whichever bank is shadow after the edge.
  assign swap    = ref_valid && (row_cnt == '0) && pend;
  assign rd_bank = swap ? ~act_bank : act_bank;
  assign wr_bank = ~rd_bank;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_bank <= 1'b0;
      pend     <= 1'b0;
    end else begin
      if (swap)        act_bank <= ~act_bank;
      if (cur_we)      pend     <= 1'b1;
      else if (swap)   pend     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cur_we) cur_mem[wr_bank][cur_addr] <= cur_row;
  end
`else
  logic [BLK*PIX_W-1:0] cur_mem [BLK];

  always_ff @(posedge clk) begin
    if (cur_we) cur_mem[cur_addr] <= cur_row;
  end
`endif

  always_comb begin
    cur_idx = '0;
    for (int unsigned dy = 0; dy < SR; dy++) begin
      cur_sel[dy] = '0;
      cur_idx     = row_cnt - 5'(dy);
      if (row_cnt >= 5'(dy) && cur_idx < 5'(BLK))
`ifdef ME_CUR_DBUF_EN
        cur_sel[dy] = cur_mem[rd_bank][cur_idx[3:0]];
`else
        cur_sel[dy] = cur_mem[cur_idx[3:0]];
`endif
    end
  end

  for (genvar g = 0; g < SR; g++) begin : g_pe
    me_sad_row_pe u_pe (
      .ref_row (ref_row),
      .cur_row (cur_sel[g]),
      .row_sad (row_sad[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst && ref_valid) begin
      for (int unsigned dy = 0; dy < SR; dy++) begin
        for (int unsigned dx = 0; dx < SR; dx++) begin
          if (row_cnt == 5'(dy))
            acc[dy][dx] <= SAD_W'(row_sad[dy][dx]);
          else if (row_cnt > 5'(dy) && row_cnt <= 5'(dy + BLK - 1))
            acc[dy][dx] <= acc[dy][dx] + SAD_W'(row_sad[dy][dx]);
        end
      end
    end
  end

  // Stage 1 samples on the same edge a back-to-back row 0 reloads acc, so it sees the finished sums.
  always_comb begin
    for (int unsigned dy = 0; dy < SR; dy++) begin
      s1_d[dy].sad = acc[dy][0];
      s1_d[dy].dx  = '0;
      s1_d[dy].dy  = MV_W'(dy);
      for (int unsigned dx = 1; dx < SR; dx++) begin
        if (acc[dy][dx] < s1_d[dy].sad) begin
          s1_d[dy].sad = acc[dy][dx];
          s1_d[dy].dx  = MV_W'(dx);
        end
      end
    end
  end

  always_comb begin
    s2_d = s1_q[0];
    for (int unsigned dy = 1; dy < SR; dy++) begin
      if (s1_q[dy].sad < s2_d.sad) s2_d = s1_q[dy];
    end
  end

  always_ff @(posedge clk) begin
    if (v0) begin
      for (int unsigned dy = 0; dy < SR; dy++) s1_q[dy] <= s1_d[dy];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0           <= 1'b0;
      v1           <= 1'b0;
      result_valid <= 1'b0;
      best_sad     <= '0;
      mv_x         <= '0;
      mv_y         <= '0;
    end else begin
      v0           <= ref_valid && row_last;
      v1           <= v0;
      result_valid <= v1;
      if (v1) begin
        best_sad <= s2_d.sad;
        mv_x     <= s2_d.dx;
        mv_y     <= s2_d.dy;
      end
    end
  end

endmodule

// File: tb/tb_me_sad_search_engine.sv
// Directed self-checking bench for me_sad_search_engine; the dbuf scenario runs when ME_CUR_DBUF_EN is defined.
module tb_me_sad_search_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [183:0] ref_row;
  logic         ref_valid;
  logic         cur_we;
  logic [3:0]   cur_addr;
  logic [127:0] cur_row;
  logic         busy;
  logic [15:0]  best_sad;
  logic [2:0]   mv_x, mv_y;
  logic         result_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int          pulse_cyc[$];
  logic [15:0] pulse_sad[$];
  logic [2:0]  pulse_x[$];
  logic [2:0]  pulse_y[$];
  int          t22[$];

  me_sad_search_engine dut (
    .clk          (clk),
    .rst          (rst),
    .ref_row      (ref_row),
    .ref_valid    (ref_valid),
    .cur_we       (cur_we),
    .cur_addr     (cur_addr),
    .cur_row      (cur_row),
    .busy         (busy),
    .best_sad     (best_sad),
    .mv_x         (mv_x),
    .mv_y         (mv_y),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_sad.push_back(best_sad);
      pulse_x.push_back(mv_x);
      pulse_y.push_back(mv_y);
    end
  end

  // kind 0: all zero, kind 1: (r*23+c) mod 256
  function automatic logic [7:0] ref_pix(int kind, int r, int c);
    return (kind == 0) ? 8'd0 : 8'((r * 23 + c) % 256);
  endfunction

  function automatic logic [183:0] mk_ref(int kind, int r);
    logic [183:0] v;
    v = '0;
    for (int c = 0; c < 23; c++) v[(22-c)*8 +: 8] = ref_pix(kind, r, c);
    return v;
  endfunction

  // kind 0: zeros, kind 1: all 255, kind 2: pattern window at (dy,dx)
  function automatic logic [127:0] mk_cur(int kind, int dy, int dx, int i);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++)
      v[(15-k)*8 +: 8] = (kind == 0) ? 8'd0 : (kind == 1) ? 8'hff : ref_pix(1, i + dy, k + dx);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pulse_sad.delete();
    pulse_x.delete();
    pulse_y.delete();
    t22.delete();
  endtask

  task automatic write_cur(int i, int kind, int dy, int dx);
    cur_we   = 1'b1;
    cur_addr = 4'(i);
    cur_row  = mk_cur(kind, dy, dx, i);
    tick();
    cur_we   = 1'b0;
  endtask

  task automatic load_cur(int kind, int dy, int dx);
    for (int i = 0; i < 16; i++) write_cur(i, kind, dy, dx);
  endtask

  // Streams rows g0..n-1 back-to-back (row = g mod 23); optionally writes cur row g-wr_from alongside.
  task automatic run_rows(int g0, int n, int kind, int wr_from, int wr_kind, int wr_dy, int wr_dx);
    for (int g = g0; g < n; g++) begin
      ref_row   = mk_ref(kind, g % 23);
      ref_valid = 1'b1;
      if (wr_from >= 0 && g >= wr_from && g - wr_from < 16) begin
        cur_we   = 1'b1;
        cur_addr = 4'(g - wr_from);
        cur_row  = mk_cur(wr_kind, wr_dy, wr_dx, g - wr_from);
      end
      tick();
      ref_valid = 1'b0;
      cur_we    = 1'b0;
      if (g % 23 == 22) t22.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    ref_valid = 1'b1;
    ref_row   = mk_ref(1, 0);
    idle(3);
    rst       = 1'b0;
    ref_valid = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b want 0", result_valid); end
    n_vec++; if (best_sad !== 16'd0) begin n_err++; $display("FAIL reset_sad: got %0d want 0", best_sad); end
    n_vec++; if (mv_x !== 3'd0 || mv_y !== 3'd0) begin n_err++; $display("FAIL reset_mv: got (%0d,%0d) want (0,0)", mv_x, mv_y); end
    idle(4);
    n_vec++; if (pulse_cyc.size() !== 0) begin n_err++; $display("FAIL reset_nopulse: got %0d pulses want 0", pulse_cyc.size()); end
  endtask

  task automatic test_zero();
    load_cur(0, 0, 0);
    clear_mon();
    run_rows(0, 1, 0, -1, 0, 0, 0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL zero_busy_mid: got %b want 1", busy); end
    run_rows(1, 23, 0, -1, 0, 0, 0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_wrap: got %b want 0", busy); end
    idle(6);
    n_vec++;
    if (pulse_cyc.size() !== 1) begin n_err++; $display("FAIL zero_count: got %0d want 1", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_cyc[0] !== t22[0] + 2) begin n_err++; $display("FAIL zero_latency: got cyc %0d want %0d", pulse_cyc[0], t22[0] + 2); end
      n_vec++; if (pulse_sad[0] !== 16'd0) begin n_err++; $display("FAIL zero_sad: got %0d want 0", pulse_sad[0]); end
      n_vec++; if (pulse_x[0] !== 3'd0 || pulse_y[0] !== 3'd0) begin n_err++; $display("FAIL zero_mv: got (%0d,%0d) want (0,0)", pulse_x[0], pulse_y[0]); end
    end
  endtask

  task automatic test_match();
    load_cur(2, 3, 5);
    clear_mon();
    run_rows(0, 23, 1, -1, 0, 0, 0);
    idle(8);
    n_vec++;
    if (pulse_cyc.size() !== 1) begin n_err++; $display("FAIL match_count: got %0d want 1", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_sad[0] !== 16'd0) begin n_err++; $display("FAIL match_sad: got %0d want 0", pulse_sad[0]); end
      n_vec++; if (pulse_x[0] !== 3'd5 || pulse_y[0] !== 3'd3) begin n_err++; $display("FAIL match_mv: got (%0d,%0d) want (5,3)", pulse_x[0], pulse_y[0]); end
    end
    n_vec++; if (mv_x !== 3'd5 || mv_y !== 3'd3) begin n_err++; $display("FAIL match_hold: got (%0d,%0d) want (5,3)", mv_x, mv_y); end
  endtask

  task automatic test_saturate();
    load_cur(1, 0, 0);
    clear_mon();
    run_rows(0, 23, 0, -1, 0, 0, 0);
    idle(6);
    n_vec++;
    if (pulse_cyc.size() !== 1) begin n_err++; $display("FAIL sat_count: got %0d want 1", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_sad[0] !== 16'd65280) begin n_err++; $display("FAIL sat_sad: got %0d want 65280", pulse_sad[0]); end
      n_vec++; if (pulse_x[0] !== 3'd0 || pulse_y[0] !== 3'd0) begin n_err++; $display("FAIL sat_tie_mv: got (%0d,%0d) want (0,0)", pulse_x[0], pulse_y[0]); end
    end
  endtask

  task automatic test_gap();
    load_cur(2, 3, 5);
    clear_mon();
    run_rows(0, 11, 1, -1, 0, 0, 0);
    idle(5);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy: got %b want 1", busy); end
    run_rows(11, 23, 1, -1, 0, 0, 0);
    idle(6);
    n_vec++;
    if (pulse_cyc.size() !== 1) begin n_err++; $display("FAIL gap_count: got %0d want 1", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_cyc[0] !== t22[0] + 2) begin n_err++; $display("FAIL gap_latency: got cyc %0d want %0d", pulse_cyc[0], t22[0] + 2); end
      n_vec++; if (pulse_sad[0] !== 16'd0 || pulse_x[0] !== 3'd5 || pulse_y[0] !== 3'd3)
        begin n_err++; $display("FAIL gap_result: got sad %0d mv (%0d,%0d) want sad 0 mv (5,3)", pulse_sad[0], pulse_x[0], pulse_y[0]); end
    end
  endtask

  task automatic test_back_to_back();
    load_cur(2, 3, 5);
    clear_mon();
    run_rows(0, 46, 1, 7, 2, 7, 0);
    idle(6);
    n_vec++;
    if (pulse_cyc.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_cyc[1] - pulse_cyc[0] !== 23) begin n_err++; $display("FAIL b2b_spacing: got %0d want 23", pulse_cyc[1] - pulse_cyc[0]); end
      n_vec++; if (pulse_sad[0] !== 16'd0 || pulse_x[0] !== 3'd5 || pulse_y[0] !== 3'd3)
        begin n_err++; $display("FAIL b2b_first: got sad %0d mv (%0d,%0d) want sad 0 mv (5,3)", pulse_sad[0], pulse_x[0], pulse_y[0]); end
      n_vec++; if (pulse_sad[1] !== 16'd0 || pulse_x[1] !== 3'd0 || pulse_y[1] !== 3'd7)
        begin n_err++; $display("FAIL b2b_second: got sad %0d mv (%0d,%0d) want sad 0 mv (0,7)", pulse_sad[1], pulse_x[1], pulse_y[1]); end
    end
  endtask

  task automatic test_reset_mid();
    load_cur(2, 3, 5);
    clear_mon();
    run_rows(0, 12, 1, -1, 0, 0, 0);
    ref_row   = mk_ref(1, 12);
    ref_valid = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    ref_valid = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (best_sad !== 16'd0) begin n_err++; $display("FAIL rstmid_sad_clr: got %0d want 0", best_sad); end
    // reset while the finished window is still in the compare pipeline
    run_rows(0, 23, 1, -1, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(6);
    n_vec++; if (pulse_cyc.size() !== 0) begin n_err++; $display("FAIL rstmid_aborted: got %0d pulses want 0", pulse_cyc.size()); end
    clear_mon();
    run_rows(0, 23, 1, -1, 0, 0, 0);
    idle(6);
    n_vec++;
    if (pulse_cyc.size() !== 1) begin n_err++; $display("FAIL rstmid_count: got %0d want 1", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_sad[0] !== 16'd0 || pulse_x[0] !== 3'd5 || pulse_y[0] !== 3'd3)
        begin n_err++; $display("FAIL rstmid_result: got sad %0d mv (%0d,%0d) want sad 0 mv (5,3)", pulse_sad[0], pulse_x[0], pulse_y[0]); end
    end
  endtask

`ifdef ME_CUR_DBUF_EN
  task automatic test_dbuf();
    clear_mon();
    run_rows(0, 23, 1, 8, 2, 7, 0);
    write_cur(15, 2, 7, 0);
    run_rows(0, 23, 1, -1, 0, 0, 0);
    idle(6);
    n_vec++;
    if (pulse_cyc.size() !== 2) begin n_err++; $display("FAIL dbuf_count: got %0d want 2", pulse_cyc.size()); end
    else begin
      n_vec++; if (pulse_sad[0] !== 16'd0 || pulse_x[0] !== 3'd5 || pulse_y[0] !== 3'd3)
        begin n_err++; $display("FAIL dbuf_current: got sad %0d mv (%0d,%0d) want sad 0 mv (5,3)", pulse_sad[0], pulse_x[0], pulse_y[0]); end
      n_vec++; if (pulse_sad[1] !== 16'd0 || pulse_x[1] !== 3'd0 || pulse_y[1] !== 3'd7)
        begin n_err++; $display("FAIL dbuf_next: got sad %0d mv (%0d,%0d) want sad 0 mv (0,7)", pulse_sad[1], pulse_x[1], pulse_y[1]); end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    ref_row   = '0;
    ref_valid = 1'b0;
    cur_we    = 1'b0;
    cur_addr  = '0;
    cur_row   = '0;
    idle(2);
    test_reset();
    test_zero();
    test_match();
    test_saturate();
    test_gap();
    test_back_to_back();
    test_reset_mid();
`ifdef ME_CUR_DBUF_EN
    test_dbuf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
